// File: rtl/cs_pkg.sv
// Shared types and elaboration helpers for the carry-save normaliser.
// Latency: none (definitions only).
// Backpressure: not applicable.
package cs_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESOLVE = 2'd1,
    NORM    = 2'd2,
    DONE    = 2'd3
  } cs_state_t;

  // Number of carry-propagate passes needed to resolve one operand pair
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Legal geometry: whole chunks, and the clamp never exceeds the operand width
  function automatic bit params_ok(input int width, input int chunk, input int shift_bits);
    return (chunk > 0) && (width % chunk == 0) && ((1 << shift_bits) <= width);
  endfunction

endpackage

// File: rtl/lead_sign_counter.sv
// Counts redundant sign bits below the MSB, clamps to the shift range, flags zero.
// Latency: combinational.
// Backpressure: none; pure function of value.
module lead_sign_counter #(
  parameter int WIDTH      = 16,
  parameter int SHIFT_BITS = 4
) (
  input  logic [WIDTH-1:0]      value,
  output logic [SHIFT_BITS-1:0] shift,
  output logic                  zero
);

  localparam int MAX_SHIFT = (1 << SHIFT_BITS) - 1;

  int   lsc;
  logic run;

  // Walk down from WIDTH-2 while bits still match the sign, then clamp
  always_comb begin
    lsc = 0;
    run = 1'b1;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      if (run && (value[i] == value[WIDTH-1])) begin
        lsc = lsc + 1;
      end else begin
        run = 1'b0;
      end
    end
    if (lsc > MAX_SHIFT) begin
      shift = SHIFT_BITS'(MAX_SHIFT);
    end else begin
      shift = SHIFT_BITS'(lsc);
    end
    zero = (value == '0);
  end

endmodule

// File: rtl/cs_normalizer.sv
// Resolves a sum/carry pair CHUNK bits per cycle, then left-normalises the result.
// Latency: out_valid rises WIDTH/CHUNK+1 cycles after the accept edge.
// Backpressure: holds result in DONE until out_ready; in_ready low from accept until handoff.
module cs_normalizer
  import cs_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int SHIFT_BITS = 4,
  parameter int CHUNK      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_sum,
  input  logic [WIDTH-1:0]      in_carry,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SHIFT_BITS-1:0] out_shift,
  output logic                  out_zero
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  generate
    if (!params_ok(WIDTH, CHUNK, SHIFT_BITS)) begin : g_bad_params
      $error("cs_normalizer: WIDTH must be a multiple of CHUNK and 2**SHIFT_BITS <= WIDTH");
    end
  endgenerate

  cs_state_t             state;
  logic [WIDTH-1:0]      op_sum;
  logic [WIDTH-1:0]      op_carry;
  logic [WIDTH-1:0]      acc;
  logic [IDXW-1:0]       idx;
  logic                  cy;
  logic [CHUNK:0]        chunk_sum;
  logic [SHIFT_BITS-1:0] norm_shift;
  logic                  norm_zero;

  // One slice of the carry-propagate adder, selected by the chunk index
  always_comb begin
    chunk_sum = {1'b0, op_sum[int'(idx)*CHUNK +: CHUNK]}
              + {1'b0, op_carry[int'(idx)*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, cy};
  end

  lead_sign_counter #(
    .WIDTH      (WIDTH),
    .SHIFT_BITS (SHIFT_BITS)
  ) u_lsc (
    .value (acc),
    .shift (norm_shift),
    .zero  (norm_zero)
  );

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_shift <= '0;
      out_zero  <= 1'b0;
      op_sum    <= '0;
      op_carry  <= '0;
      acc       <= '0;
      idx       <= '0;
      cy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_sum   <= in_sum;
            op_carry <= in_carry;
            idx      <= '0;
            cy       <= 1'b0;
            in_ready <= 1'b0;
            state    <= RESOLVE;
          end
        end
        RESOLVE: begin
          // Carry out of the top chunk is dropped: the sum wraps mod 2**WIDTH
          acc[int'(idx)*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          cy <= chunk_sum[CHUNK];
          if (idx == LAST_IDX) begin
            state <= NORM;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        NORM: begin
          out_data  <= acc << norm_shift;
          out_shift <= norm_shift;
          out_zero  <= norm_zero;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_normalizer.sv
// Randomised and directed bench for cs_normalizer at SHIFT_BITS 4 and 3.
// Latency: checks 5-cycle accept-to-valid at WIDTH=16, CHUNK=4.
// Backpressure: stalls out_ready and pokes in_valid while busy.
module tb_cs_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_sum;
  logic [15:0] in_carry;
  logic        out_ready;

  logic        in_ready,  in_ready2;
  logic        out_valid, out_valid2;
  logic [15:0] out_data,  out_data2;
  logic [3:0]  out_shift;
  logic [2:0]  out_shift2;
  logic        out_zero,  out_zero2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cs_normalizer #(.WIDTH(16), .SHIFT_BITS(4), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_shift(out_shift),
    .out_zero(out_zero)
  );

  cs_normalizer #(.WIDTH(16), .SHIFT_BITS(3), .CHUNK(4)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_sum(in_sum), .in_carry(in_carry), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_shift(out_shift2),
    .out_zero(out_zero2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: wrap-around sum, then the largest left shift that leaves the
  // value unchanged when arithmetically shifted back, capped by the shift range.
  task automatic model(input logic [15:0] s, input logic [15:0] c, input int max_shift,
                       output logic [15:0] d, output int sh, output bit z);
    logic [15:0] r;
    logic [15:0] t;
    int lsc;
    r   = s + c;
    lsc = 0;
    for (int k = 1; k <= 15; k++) begin
      t = r << k;
      if (($signed(t) >>> k) == $signed(r)) lsc = k;
      else break;
    end
    sh = (lsc < max_shift) ? lsc : max_shift;
    d  = r << sh;
    z  = (r == 16'h0000);
  endtask

  task automatic do_op(input logic [15:0] s, input logic [15:0] c, input int stall, input bit poke);
    logic [15:0] d4, d3;
    int sh4, sh3, t, lat;
    bit z4, z3;
    model(s, c, 15, d4, sh4, z4);
    model(s, c, 7,  d3, sh3, z3);
    t = 0;
    while (!(in_ready && in_ready2) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("idle_wait", 32'(t < 50), 32'd1);
    in_valid = 1'b1;
    in_sum   = s;
    in_carry = c;
    @(negedge clk);
    in_valid = 1'b0;
    in_sum   = 16'($urandom);
    in_carry = 16'($urandom);
    check("busy_in_ready", {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd5);
    check("valid_s3", {31'd0, out_valid2}, 32'd1);
    check("data_s4", {16'd0, out_data}, {16'd0, d4});
    check("shift_s4", {28'd0, out_shift}, 32'(sh4));
    check("zero_s4", {31'd0, out_zero}, {31'd0, z4});
    check("data_s3", {16'd0, out_data2}, {16'd0, d3});
    check("shift_s3", {29'd0, out_shift2}, 32'(sh3));
    check("zero_s3", {31'd0, out_zero2}, {31'd0, z3});
    for (int k = 0; k < stall; k++) begin
      in_valid = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      in_sum   = 16'($urandom);
      in_carry = 16'($urandom);
      @(negedge clk);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_data", {16'd0, out_data}, {16'd0, d4});
      check("stall_shift", {28'd0, out_shift}, 32'(sh4));
      check("stall_rdy", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", {30'd0, out_valid, out_valid2}, 32'd0);
    check("post_rdy", {30'd0, in_ready, in_ready2}, 32'd3);
    check("post_hold", {16'd0, out_data}, {16'd0, d4});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [15:0] s, r;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_carry  = '0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_out_shift", {28'd0, out_shift}, 32'd0);
    check("rst_out_zero", {31'd0, out_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    do_op(16'h0003, 16'h0005, 0, 1'b0);
    do_op(16'hFFF0, 16'hFFF8, 1, 1'b0);
    do_op(16'h1234, 16'hEDCC, 0, 1'b0);
    do_op(16'h0001, 16'h0000, 0, 1'b0);
    do_op(16'h4000, 16'h0000, 2, 1'b0);
    do_op(16'hFFFF, 16'h0000, 0, 1'b0);
    do_op(16'h8000, 16'h0000, 0, 1'b0);
    // Long back-pressure with in_valid poked while busy, then a follow-up pair
    do_op(16'h7FFF, 16'h0002, 10, 1'b1);
    do_op(16'h0100, 16'h0100, 0, 1'b0);

    // Reset two cycles into RESOLVE
    in_valid = 1'b1;
    in_sum   = 16'h0003;
    in_carry = 16'h0005;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_data", {16'd0, out_data}, 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid || out_valid2) seen++;
    end
    check("midrst_no_valid", 32'(seen), 32'd0);
    do_op(16'h0003, 16'h0005, 0, 1'b0);

    // Randomised pairs; half aimed at small magnitudes to spread the shift range
    for (int n = 0; n < 40; n++) begin
      s = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        r = 16'($urandom_range(0, 600));
        if ($urandom_range(0, 1) == 1) r = -r;
        do_op(s, r - s, $urandom_range(0, 3), 1'b1);
      end else begin
        do_op(s, 16'($urandom), $urandom_range(0, 3), 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
